// File: rtl/gpio_wr_arb.sv
// gpio_wr_arb: round-robin arbiter serializing masked GPIO data/enable writes from several requesters.
// A grant captures the winner's write, issues it one cycle later, then enforces MinGap idle cycles.
module gpio_wr_arb #(
    parameter int NumReq = 4,
    parameter int Width  = 32,
    parameter int MinGap = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq-1:0]       sel_oe_i,
    input  logic [NumReq*Width-1:0] mask_i,
    input  logic [NumReq*Width-1:0] data_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic                    out_we_o,
    output logic                    oe_we_o,
    output logic [Width-1:0]        wr_mask_o,
    output logic [Width-1:0]        wr_data_o,
    output logic                    busy_o
);
    localparam int PW = $clog2(NumReq);
    localparam logic [3:0] GapLoad = (MinGap > 0) ? 4'(MinGap - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, win, kk;
    logic [PW:0]       k;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_q, sel_d, armed_q, found, grant, win_sel;
    logic [Width-1:0]  mask_q, mask_d, data_q, data_d, win_mask, win_data;
    logic [Width-1:0]  mask_a [NumReq];
    logic [Width-1:0]  data_a [NumReq];

    for (genvar g = 0; g < NumReq; g++) begin : g_split
        assign mask_a[g] = mask_i[g*Width +: Width];
        assign data_a[g] = data_i[g*Width +: Width];
    end

    // Scan upward from the pointer with wrap-around; first requester found wins.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_sel  = 1'b0;
        win_mask = '0;
        win_data = '0;
        k        = '0;
        kk       = '0;
        for (int i = 0; i < NumReq; i++) begin
            k  = {1'b0, ptr_q} + (PW+1)'(i);
            kk = (k >= (PW+1)'(NumReq)) ? PW'(k - (PW+1)'(NumReq)) : PW'(k);
            if (!found && req_i[kk]) begin
                found    = 1'b1;
                win      = kk;
                win_sel  = sel_oe_i[kk];
                win_mask = mask_a[kk];
                win_data = data_a[kk];
            end
        end
    end

    // armed_q holds off grants until the first clock edge after reset release.
    assign grant = armed_q && (state_q == IDLE) && found;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        data_d  = data_q;
        if (grant) begin
            ptr_d = (win == PW'(NumReq - 1)) ? '0 : win + PW'(1);
            if (|win_mask) begin
                state_d = ISSUE;
                sel_d   = win_sel;
                mask_d  = win_mask;
                data_d  = win_data;
            end
        end else if (state_q == ISSUE) begin
            state_d = (MinGap > 0) ? GAP : IDLE;
            cnt_d   = GapLoad;
        end else if (state_q == GAP) begin
            state_d = (cnt_q == 4'd0) ? IDLE : GAP;
            cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            mask_q  <= '0;
            data_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            armed_q <= 1'b1;
        end
    end

    assign gnt_o     = grant ? (NumReq'(1) << win) : '0;
    assign out_we_o  = (state_q == ISSUE) && !sel_q;
    assign oe_we_o   = (state_q == ISSUE) && sel_q;
    assign wr_mask_o = mask_q;
    assign wr_data_o = data_q;
    assign busy_o    = state_q != IDLE;
endmodule
